// File: rtl/serial_add_sequencer_if.sv
// Operand/result handshake bundle for serial_add_sequencer.
// master: operand producer / result consumer. slave: the sequencer.
interface serial_add_sequencer_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_cout
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_cout
    );

endinterface

// File: rtl/serial_add_sequencer.sv
// Word-level front/back end for a 1-bit serial adder.
// Takes an operand pair, pulses the adder carry clear, streams the operands
// LSB-first, collects the returned sum bits and presents the word result.
// Optional feature macro: SERIAL_ADD_SEQ_COUT_EN (registered final carry out
// on out_cout; when undefined out_cout is tied low).
module serial_add_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_add_sequencer_if.slave  bus,
    output logic                   ser_a,
    output logic                   ser_b,
    output logic                   ser_clr,
    input  logic                   ser_sum
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q,   state_nxt;
    logic [WIDTH-1:0] opa_q,     opa_nxt;
    logic [WIDTH-1:0] opb_q,     opb_nxt;
    logic [WIDTH-1:0] res_q,     res_nxt;
    logic [CNT_W-1:0] cnt_q,     cnt_nxt;
    logic             in_ready_q,  in_ready_nxt;
    logic             out_valid_q, out_valid_nxt;
    logic             ser_a_q,   ser_a_nxt;
    logic             ser_b_q,   ser_b_nxt;
    logic             ser_clr_q, ser_clr_nxt;
`ifdef SERIAL_ADD_SEQ_COUT_EN
    logic             cout_q,    cout_nxt;
    logic             cin_c;
`endif

    // Next-state, datapath and registered-output next values
    always_comb begin
        state_nxt     = state_q;
        opa_nxt       = opa_q;
        opb_nxt       = opb_q;
        res_nxt       = res_q;
        cnt_nxt       = cnt_q;
        in_ready_nxt  = 1'b0;
        out_valid_nxt = 1'b0;
        ser_a_nxt     = 1'b0;
        ser_b_nxt     = 1'b0;
        ser_clr_nxt   = 1'b0;
`ifdef SERIAL_ADD_SEQ_COUT_EN
        cout_nxt      = cout_q;
        cin_c         = ser_a_q ^ ser_b_q ^ ser_sum;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    opa_nxt   = bus.in_a;
                    opb_nxt   = bus.in_b;
                    cnt_nxt   = '0;
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                res_nxt = {ser_sum, res_q[WIDTH-1:1]};
                opa_nxt = opa_q >> 1;
                opb_nxt = opb_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    state_nxt = ST_DONE;
`ifdef SERIAL_ADD_SEQ_COUT_EN
                    // Recover the incoming carry from the sum bit, then form carry out
                    cout_nxt  = (ser_a_q & ser_b_q) | (cin_c & (ser_a_q ^ ser_b_q));
`endif
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state
        in_ready_nxt  = (state_nxt == ST_IDLE);
        out_valid_nxt = (state_nxt == ST_DONE);
        ser_clr_nxt   = (state_nxt == ST_CLEAR);
        ser_a_nxt     = (state_nxt == ST_SHIFT) & opa_nxt[0];
        ser_b_nxt     = (state_nxt == ST_SHIFT) & opb_nxt[0];
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ser_a_q     <= 1'b0;
            ser_b_q     <= 1'b0;
            ser_clr_q   <= 1'b0;
`ifdef SERIAL_ADD_SEQ_COUT_EN
            cout_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_nxt;
            opa_q       <= opa_nxt;
            opb_q       <= opb_nxt;
            res_q       <= res_nxt;
            cnt_q       <= cnt_nxt;
            in_ready_q  <= in_ready_nxt;
            out_valid_q <= out_valid_nxt;
            ser_a_q     <= ser_a_nxt;
            ser_b_q     <= ser_b_nxt;
            ser_clr_q   <= ser_clr_nxt;
`ifdef SERIAL_ADD_SEQ_COUT_EN
            cout_q      <= cout_nxt;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = res_q;
    assign ser_a         = ser_a_q;
    assign ser_b         = ser_b_q;
    assign ser_clr       = ser_clr_q;
`ifdef SERIAL_ADD_SEQ_COUT_EN
    assign bus.out_cout  = cout_q;
`else
    assign bus.out_cout  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Bench for serial_add_sequencer with a behavioural 1-bit serial adder
// whose carry register is reset by (rst | ser_clr).
module tb_serial_add_sequencer;

    localparam int unsigned W = 8;
`ifdef SERIAL_ADD_SEQ_COUT_EN
    localparam bit COUT_ON = 1'b1;
`else
    localparam bit COUT_ON = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic ser_a, ser_b, ser_clr, ser_sum;
    logic carry;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int acc_cnt     = 0;
    int out_times[$];
    logic [W:0] sb[$];

    serial_add_sequencer_if #(.WIDTH(W)) bus ();

    serial_add_sequencer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .ser_a   (ser_a),
        .ser_b   (ser_b),
        .ser_clr (ser_clr),
        .ser_sum (ser_sum)
    );

    always #5 clk = ~clk;

    // Serial adder model
    assign ser_sum = ser_a ^ ser_b ^ carry;
    always_ff @(posedge clk) begin
        if (rst | ser_clr) carry <= 1'b0;
        else               carry <= (ser_a & ser_b) | (carry & (ser_a ^ ser_b));
    end

    always_ff @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Accept counter and result scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_valid && bus.in_ready) acc_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                out_times.push_back(cyc);
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_result: got %h required none", {bus.out_cout, bus.out_sum});
                end else begin
                    check("result", 32'({bus.out_cout, bus.out_sum}), 32'(sb.pop_front()));
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    endtask

    // Present one operand pair for exactly one accept; returns 1 time unit after the accept edge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W:0] exp, input bit push);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        if (push) sb.push_back(exp);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic wait_acc(input int target);
        int n = 0;
        while (acc_cnt < target && n < 60) begin
            @(posedge clk); n++;
        end
        if (acc_cnt < target) check("accept_timeout", 32'(acc_cnt), 32'(target));
        #1;
    endtask

    initial begin
        vec_t vecs[8];
        int   bad;
        int   n;
        int   n0;
        int   a0;

        vecs[0] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[2] = '{8'hC3, 8'h3C, 8'hFF, 1'b0};
        vecs[3] = '{8'h99, 8'h99, 8'h32, 1'b1};
        vecs[4] = '{8'h01, 8'hFF, 8'h00, 1'b1};
        vecs[5] = '{8'h7F, 8'h7F, 8'hFE, 1'b0};
        vecs[6] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
        vecs[7] = '{8'h80, 8'h01, 8'h81, 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_sum",   32'(bus.out_sum),   32'd0);
        check("rst_out_cout",  32'(bus.out_cout),  32'd0);
        check("rst_ser",       32'({ser_a, ser_b, ser_clr}), 32'd0);

        // Latency: 0x5A + 0x33, out_valid rises in the cycle after edge E+9
        bus.out_ready = 1'b1;
        send(8'h5A, 8'h33, {1'b0, 8'h8D}, 1'b1);
        check("clear_pulse", 32'({ser_clr, bus.in_ready}), 32'b10);
        repeat (8) begin @(posedge clk); #1; end
        check("lat_not_yet", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_valid", 32'(bus.out_valid), 32'd1);
        check("lat_sum",   32'(bus.out_sum),   32'h8D);
        wait_drain();

        // Table of operand pairs (FF+01 then 00+00 shows carry cleared between ops)
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, {vecs[i].exp_cout & COUT_ON, vecs[i].exp_sum}, 1'b1);
            wait_drain();
        end

        // Backpressure: hold out_ready low for 5 cycles on 0x10 + 0x20
        bus.out_ready = 1'b0;
        send(8'h10, 8'h20, {1'b0, 8'h30}, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 40) begin @(posedge clk); #1; n++; end
        check("bp_valid_rise", 32'(bus.out_valid), 32'd1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!bus.out_valid || bus.out_sum != 8'h30 || bus.in_ready) bad++;
            @(posedge clk); #1;
        end
        check("bp_hold_stable", 32'(bad), 32'd0);
        check("bp_not_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_ready_after", 32'(bus.in_ready), 32'd1);
        check("bp_valid_drop",  32'(bus.out_valid), 32'd0);
        wait_drain();

        // in_valid held with changing operands during an operation on 0x01 + 0x02
        bus.out_ready = 1'b0;
        wait_ready();
        a0 = acc_cnt;
        bus.in_valid = 1'b1;
        bus.in_a     = 8'h01;
        bus.in_b     = 8'h02;
        sb.push_back({1'b0, 8'h03});
        @(posedge clk); #1;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            bus.in_a = W'($urandom);
            bus.in_b = W'($urandom);
            @(posedge clk); #1; n++;
        end
        bus.in_valid = 1'b0;
        check("busy_one_accept", 32'(acc_cnt - a0), 32'd1);
        bus.out_ready = 1'b1;
        wait_drain();

        // Reset during SHIFT cycle 3 of 0xAA + 0x55: no result may appear
        send(8'hAA, 8'h55, '0, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_idle", 32'({bus.in_ready, bus.out_valid, ser_a, ser_b, ser_clr}), 32'b10000);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.out_valid) bad++;
            @(posedge clk); #1;
        end
        check("abort_no_valid", 32'(bad), 32'd0);
        send(8'h0F, 8'h01, {1'b0, 8'h10}, 1'b1);
        wait_drain();

        // Back-to-back with in_valid and out_ready held high
        bus.out_ready = 1'b1;
        wait_ready();
        sb.push_back({COUT_ON, 8'h00});
        sb.push_back({1'b0, 8'h80});
        n0 = out_times.size();
        a0 = acc_cnt;
        bus.in_valid = 1'b1;
        bus.in_a     = 8'h80;
        bus.in_b     = 8'h80;
        wait_acc(a0 + 1);
        bus.in_a = 8'h7F;
        bus.in_b = 8'h01;
        wait_acc(a0 + 2);
        bus.in_valid = 1'b0;
        wait_drain();
        check("b2b_count", 32'(out_times.size() - n0), 32'd2);
        if (out_times.size() - n0 == 2)
            check("b2b_spacing", 32'(out_times[n0+1] - out_times[n0]), 32'd11);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
        $fatal(1);
    end

endmodule
